// File: rtl/i4_mode_sched_pkg.sv
// Shared types and constants for the intra-4x4 mode-decision sequencer.
package i4_mode_sched_pkg;

  // Sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_COST = 3'd2,
    S_REC_REQ   = 3'd3,
    S_REC_WAIT  = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // Intra-4x4 luma prediction modes in evaluation order.
  localparam logic [3:0] I4_DC = 4'd0;
  localparam logic [3:0] I4_TM = 4'd1;
  localparam logic [3:0] I4_VE = 4'd2;
  localparam logic [3:0] I4_HE = 4'd3;
  localparam logic [3:0] I4_LD = 4'd4;
  localparam logic [3:0] I4_RD = 4'd5;
  localparam logic [3:0] I4_VR = 4'd6;
  localparam logic [3:0] I4_VL = 4'd7;
  localparam logic [3:0] I4_HD = 4'd8;
  localparam logic [3:0] I4_HU = 4'd9;

  // Sub-blocks per 16x16 macroblock.
  localparam int I4_BLOCKS = 16;

endpackage

// File: rtl/i4_mode_sched.sv
// Intra-4x4 mode-decision sequencer for one macroblock: walks the sixteen
// sub-blocks, issues every candidate mode to the cost evaluator, keeps the
// cheapest, requests reconstruction and strobes the neighbour buffer.
//
// Handshakes: a request transfers on the rising edge where valid and ready
// are both high; valid never depends on ready, and the payload (mode,
// rec_mode, i4) is held constant while valid is high and ready is low.
// cost_valid and rec_done are single-cycle responses accepted only in the
// state that waits for them.
module i4_mode_sched
  import i4_mode_sched_pkg::*;
#(
  parameter int NUM_MODES = 10,
  parameter int COST_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        i4,
  output logic              load,
  output logic              mode_valid,
  input  logic              mode_ready,
  output logic [3:0]        mode,
  input  logic              cost_valid,
  input  logic [COST_W-1:0] cost,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [3:0]        rec_mode,
  input  logic              rec_done,
  output logic [63:0]       mode_map,
  output state_t            dbg_state
);

  localparam logic [3:0] LAST_MODE = 4'(NUM_MODES - 1);
  localparam logic [4:0] LAST_I4   = 5'(I4_BLOCKS - 1);

  state_t              state_q, state_d;
  logic [4:0]          i4_q, i4_d;
  logic [3:0]          mode_q, mode_d;
  logic [COST_W-1:0]   best_cost_q, best_cost_d;
  logic [3:0]          best_mode_q, best_mode_d;
  logic [63:0]         map_q, map_d;

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i4_q        <= '0;
      mode_q      <= '0;
      best_cost_q <= '0;
      best_mode_q <= '0;
      map_q       <= '0;
    end else begin
      state_q     <= state_d;
      i4_q        <= i4_d;
      mode_q      <= mode_d;
      best_cost_q <= best_cost_d;
      best_mode_q <= best_mode_d;
      map_q       <= map_d;
    end
  end

  // Next-state logic, min-cost tracking and mode-map update.
  always_comb begin
    state_d     = state_q;
    i4_d        = i4_q;
    mode_d      = mode_q;
    best_cost_d = best_cost_q;
    best_mode_d = best_mode_q;
    map_d       = map_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          i4_d        = '0;
          mode_d      = I4_DC;
          best_cost_d = '0;
          best_mode_d = I4_DC;
          map_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mode_ready) state_d = S_WAIT_COST;
      end
      S_WAIT_COST: begin
        if (cost_valid) begin
          // The first candidate seeds the tracker; later ones must be
          // strictly cheaper, so ties stay with the lower mode index.
          if (mode_q == I4_DC || cost < best_cost_q) begin
            best_cost_d = cost;
            best_mode_d = mode_q;
          end
          if (mode_q == LAST_MODE) begin
            state_d = S_REC_REQ;
          end else begin
            mode_d  = mode_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_REC_REQ: begin
        if (rec_ready) begin
          map_d[{i4_q[3:0], 2'b00} +: 4] = best_mode_q;
          state_d = S_REC_WAIT;
        end
      end
      S_REC_WAIT: begin
        if (rec_done) begin
          if (i4_q == LAST_I4) begin
            state_d = S_FINISH;
          end else begin
            i4_d    = i4_q + 5'd1;
            mode_d  = I4_DC;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any transition; partial results are left in place.
    if (abort) begin
      state_d     = S_IDLE;
      i4_d        = i4_q;
      mode_d      = mode_q;
      best_cost_d = best_cost_q;
      best_mode_d = best_mode_q;
      map_d       = map_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH) & ~abort;
  assign load       = (state_q == S_REC_WAIT) & rec_done & ~abort;
  assign mode_valid = (state_q == S_ISSUE);
  assign rec_valid  = (state_q == S_REC_REQ);
  assign mode       = mode_q;
  assign rec_mode   = best_mode_q;
  assign i4         = i4_q;
  assign mode_map   = map_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i4_mode_sched.sv
// Directed bench for the intra-4x4 mode-decision sequencer. A reference
// model of the expected phase, with scoreboard queues for chosen modes and
// neighbour-buffer loads, is advanced one cycle at a time alongside the DUT.
module tb_i4_mode_sched;
  import i4_mode_sched_pkg::*;

  localparam int NM = 10;
  localparam int CW = 32;
  localparam int BUDGET = 6000;

  typedef enum int {P_IDLE, P_ISSUE, P_WAIT_COST, P_REC_REQ, P_REC_WAIT, P_FINISH} phase_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, load, mode_valid, rec_valid;
  logic [4:0]    i4;
  logic          mode_ready = 1'b0;
  logic [3:0]    mode, rec_mode;
  logic          cost_valid = 1'b0;
  logic [CW-1:0] cost = '0;
  logic          rec_ready = 1'b0;
  logic          rec_done = 1'b0;
  logic [63:0]   mode_map;
  state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected chosen mode per sub-block, expected i4 per load.
  logic [3:0] exp_q[$];
  logic [4:0] load_q[$];

  int          cost_tab[16][NM];
  logic [63:0] exp_map;
  int          load_cnt;
  int          done_cyc;

  i4_mode_sched #(.NUM_MODES(NM), .COST_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .i4         (i4),
    .load       (load),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .mode       (mode),
    .cost_valid (cost_valid),
    .cost       (cost),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_mode   (rec_mode),
    .rec_done   (rec_done),
    .mode_map   (mode_map),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: mode 3 cheapest, kind 1: all equal, kind 2: random with ties.
  task automatic fill_costs(input int kind);
    for (int b = 0; b < 16; b++)
      for (int m = 0; m < NM; m++)
        case (kind)
          0:       cost_tab[b][m] = (m == 3) ? 5 : 100;
          1:       cost_tab[b][m] = 7;
          default: cost_tab[b][m] = $urandom_range(1, 20);
        endcase
  endtask

  function automatic logic [3:0] best_of(input int b);
    int bm = 0;
    int bc = cost_tab[b][0];
    for (int m = 1; m < NM; m++)
      if (cost_tab[b][m] < bc) begin
        bc = cost_tab[b][m];
        bm = m;
      end
    return 4'(bm);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_i4"}, i4, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_mode_valid"}, mode_valid, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_rec_valid"}, rec_valid, 0);
    chk({tag, "_rec_mode"}, rec_mode, 0);
    chk({tag, "_mode_map"}, mode_map, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // Runs one macroblock as the peers; abort_blk/rst_blk >= 0 cut it short.
  task automatic run_mb(input bit stall, input bit spur, input int abort_blk,
                        input int rst_blk, input int mid_start_cyc);
    phase_t ph = P_IDLE;
    int cyc = 0;
    int blk = 0;
    int m = 0;
    int cdly = 0;
    int rdly = 0;
    bit cost_real, rec_real, exp_load, stop;
    logic [3:0] em;
    logic [4:0] el;
    stop = 0;
    load_cnt = 0;
    done_cyc = -1;
    exp_q.delete();
    load_q.delete();
    while (!stop) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == mid_start_cyc);
      abort = 0; mode_ready = 0; rec_ready = 0;
      cost_valid = 0; cost = '0; rec_done = 0;
      cost_real = 0; rec_real = 0;
      case (ph)
        P_ISSUE: begin
          mode_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (spur && $urandom_range(0, 3) == 0) begin cost_valid = 1; cost = '0; end
          if (spur && $urandom_range(0, 3) == 0) rec_done = 1;
        end
        P_WAIT_COST: begin
          if (cdly == 0) begin
            cost_valid = 1; cost_real = 1; cost = CW'(cost_tab[blk][m]);
          end else cdly--;
          if (spur && $urandom_range(0, 2) == 0) rec_done = 1;
        end
        P_REC_REQ: begin
          rec_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (spur && $urandom_range(0, 3) == 0) begin cost_valid = 1; cost = '0; end
        end
        P_REC_WAIT: begin
          if (rdly == 0) begin
            rec_done = 1; rec_real = 1;
            if (blk == abort_blk) abort = 1;
          end else rdly--;
        end
        default: ;
      endcase
      if (ph == P_WAIT_COST && blk == rst_blk) begin
        rst_n = 0;
        cost_valid = 0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1;
        return;
      end
      #1;
      chk("busy", busy, ph != P_IDLE);
      chk("mode_valid", mode_valid, ph == P_ISSUE);
      chk("rec_valid", rec_valid, ph == P_REC_REQ);
      chk("done", done, ph == P_FINISH);
      exp_load = (ph == P_REC_WAIT) && rec_real && !abort;
      chk("load", load, exp_load);
      if (ph != P_IDLE) chk("i4", i4, blk);
      if (ph == P_ISSUE) chk("mode", mode, m);
      if (ph == P_REC_REQ) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
        else chk("rec_mode_stable", rec_mode, exp_q[0]);
      end
      if (ph == P_FINISH) begin
        chk("mode_map_done", mode_map, exp_map);
        done_cyc = cyc;
      end
      // Advance the reference model across the coming clock edge.
      if (abort) begin
        ph = P_IDLE;
        stop = 1;
      end else begin
        case (ph)
          P_IDLE: begin
            if (start) begin
              ph = P_ISSUE; blk = 0; m = 0; exp_map = '0;
              exp_q.push_back(best_of(0));
            end
          end
          P_ISSUE: begin
            if (mode_ready) begin
              ph = P_WAIT_COST;
              cdly = stall ? $urandom_range(0, 3) : 0;
            end
          end
          P_WAIT_COST: begin
            if (cost_real) begin
              if (m == NM - 1) ph = P_REC_REQ;
              else begin m++; ph = P_ISSUE; end
            end
          end
          P_REC_REQ: begin
            if (rec_ready) begin
              em = exp_q.pop_front();
              chk("rec_mode", rec_mode, em);
              exp_map[blk*4 +: 4] = em;
              load_q.push_back(5'(blk));
              ph = P_REC_WAIT;
              rdly = stall ? $urandom_range(0, 4) : 0;
            end
          end
          P_REC_WAIT: begin
            if (rec_real) begin
              if (load_q.size() == 0) chk("load_q_empty", 1, 0);
              else begin
                el = load_q.pop_front();
                chk("load_i4", i4, el);
              end
              if (load) load_cnt++;
              if (blk == 15) ph = P_FINISH;
              else begin
                blk++; m = 0; ph = P_ISSUE;
                exp_q.push_back(best_of(blk));
              end
            end
          end
          P_FINISH: begin
            ph = P_IDLE;
            stop = 1;
          end
          default: ph = P_IDLE;
        endcase
      end
      cyc++;
      if (cyc > BUDGET) begin
        chk("timeout", cyc, BUDGET);
        stop = 1;
      end
    end
    // Cycle after done/abort: back to idle, nothing pending.
    @(negedge clk);
    start = 0; abort = 0; mode_ready = 0; rec_ready = 0;
    cost_valid = 0; rec_done = 0;
    #1;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("state_after", dbg_state, S_IDLE);
    chk("map_after", mode_map, exp_map);
  endtask

  initial begin
    // Reset
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Zero-wait peers, mode 3 cheapest, second start mid-run ignored.
    fill_costs(0);
    run_mb(0, 0, -1, -1, 100);
    chk("mb1_done_cycle", done_cyc, 353);
    chk("mb1_loads", load_cnt, 16);
    chk("mb1_map", mode_map, 64'h3333_3333_3333_3333);

    // Equal costs: ties keep mode 0.
    fill_costs(1);
    run_mb(0, 0, -1, -1, -1);
    chk("mb2_done_cycle", done_cyc, 353);
    chk("mb2_map", mode_map, 64'h0);

    // Random costs, stalls, delays and spurious responses.
    fill_costs(2);
    run_mb(1, 1, -1, -1, -1);
    chk("mb3_loads", load_cnt, 16);
    chk("mb3_map", mode_map, exp_map);

    // Abort in sub-block 7 REC_WAIT with rec_done high.
    fill_costs(0);
    run_mb(0, 0, 7, -1, -1);
    chk("abort_no_done", done_cyc, -1);
    chk("abort_loads", load_cnt, 7);
    chk("abort_partial_map", mode_map, 64'h0000_0000_3333_3333);

    // Restart after abort begins at i4 = 0.
    fill_costs(2);
    run_mb(1, 0, -1, -1, -1);
    chk("restart_loads", load_cnt, 16);
    chk("restart_map", mode_map, exp_map);

    // Async reset while waiting for a cost, then a full clean run.
    fill_costs(0);
    run_mb(0, 0, -1, 2, -1);
    @(negedge clk);
    #1;
    check_all_zero("post_reset");
    run_mb(0, 1, -1, -1, -1);
    chk("post_reset_map", mode_map, 64'h3333_3333_3333_3333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i4_mode_sched.md
# i4_mode_sched

Sequencer for intra-4x4 luma mode decision and reconstruction of one 16x16 macroblock. Walks sub-blocks i4 = 0..15 in raster order. For each sub-block it issues every candidate prediction mode to the cost evaluator and keeps the minimum-cost mode, then requests reconstruction with that mode. When the reconstructed 4x4 block returns, it pulses `load` so the I4 neighbour-rotation buffer captures the new block's bottom row. It sits between the macroblock top-level control and the I4 predict/cost/reconstruct datapath, and drives the `i4` and `load` inputs of the neighbour buffer.

## Interface
Parameters:
- `NUM_MODES`, 10, candidate I4 modes per sub-block, evaluated as 0..NUM_MODES-1 (2..16).
- `COST_W`, 32, width of the unsigned cost from the evaluator.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a macroblock; sampled only in IDLE.
- `abort`  in  1  synchronous abandon of the current macroblock.
- `busy`  out  1  high from the cycle after an accepted start until done/abort.
- `done`  out  1  one-cycle pulse; macroblock complete, `mode_map` valid.
- `i4`  out  5  current sub-block index 0..15, to neighbour buffer and datapath.
- `load`  out  1  neighbour-buffer capture strobe (combinational).
- `mode_valid`  out  1  candidate-mode request valid.
- `mode_ready`  in  1  evaluator accepts the candidate.
- `mode`  out  4  candidate mode index.
- `cost_valid`  in  1  cost for the outstanding candidate.
- `cost`  in  COST_W  cost value.
- `rec_valid`  out  1  reconstruct request valid.
- `rec_ready`  in  1  reconstructor accepts the request.
- `rec_mode`  out  4  chosen mode for the current sub-block.
- `rec_done`  in  1  reconstruction finished; Yin valid this cycle.
- `mode_map`  out  64  chosen modes, sub-block k at bits [4k+3:4k].

## Operation
- FSM states: IDLE, ISSUE, WAIT_COST, REC_REQ, REC_WAIT, FINISH.
- IDLE: `start` loads i4=0, mode=0, clears `mode_map` and the best-cost register, then goes to ISSUE.
- ISSUE: assert `mode_valid`. On `mode_valid & mode_ready`, go to WAIT_COST. Exactly one candidate is outstanding at a time.
- WAIT_COST: on `cost_valid`, compare against the best cost:
  - mode 0 always initialises best.
  - Otherwise best updates only if `cost` < best (strict, unsigned). Ties keep the lower mode index.
  - If mode == NUM_MODES-1, go to REC_REQ. Otherwise increment mode and go to ISSUE.
- REC_REQ: assert `rec_valid` with `rec_mode` = best mode. On handshake, write best mode into `mode_map[i4]` and go to REC_WAIT.
- REC_WAIT: `load = rec_done` in this state, same cycle, no register.
  - On `rec_done` with i4 < 15: increment i4, reset mode to 0, go to ISSUE.
  - On `rec_done` with i4 == 15: go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE. `i4` holds 15 until the next start.
- `cost_valid` outside WAIT_COST and `rec_done` outside REC_WAIT are ignored; no `load` is generated.
- `start` while busy is ignored.
- `abort` has priority over every transition: go to IDLE next cycle, no `done`, no `load` that cycle. `mode_map` keeps partial contents.
- Request payloads (`mode`, `rec_mode`, `i4`) stay stable while valid is high and ready is low.

## Timing
- Reset: all outputs 0, state IDLE, best cost 0, `mode_map` 0.
- start→first `mode_valid`: 1 cycle.
- Per candidate, minimum 2 cycles (ISSUE with ready=1, then WAIT_COST with cost_valid=1).
- Per sub-block, minimum 2·NUM_MODES + 2 cycles.
- Full macroblock with zero-wait peers: 16·(2·NUM_MODES+2) cycles to last `load`, then `done` one cycle later (NUM_MODES=10: 352 + 1).
- `busy` falls in the cycle after `done` and in the cycle after `abort`.
- Asynchronous reset mid-macroblock aborts immediately. No outstanding-request bookkeeping survives.

## Structure
- Shared package: state encoding enum, the I4 mode constants (DC, TM, VE, HE, LD, RD, VR, VL, HD, HU = 0..9), and `I4_BLOCKS` = 16.
- Single module; no sub-module needed. The min-cost tracker is a few registers inside the FSM body.

## Test plan
- Zero-wait peers, cost = (mode==3 ? 5 : 100) for every sub-block → `rec_mode`=3 sixteen times, `mode_map`=64'h3333_3333_3333_3333, `done` at cycle 353 after start.
- Equal costs (all 7) → mode 0 chosen everywhere; ties never move to a higher mode.
- Random `mode_ready`/`rec_ready` stalls and delayed `cost_valid`/`rec_done` → payloads stable under stall, exactly 16 `load` pulses, each coincident with `rec_done` with i4 = 0..15 in order.
- Spurious `cost_valid` in ISSUE and `rec_done` in WAIT_COST → no state change, no `load`.
- `abort` asserted during sub-block 7 REC_WAIT with `rec_done` high the same cycle → no `load`, no `done`, IDLE next cycle; a new `start` restarts at i4=0.
- `rst_n` pulsed low mid-WAIT_COST → all outputs 0 immediately; `start` ignored while busy is verified by a second start pulse mid-run having no effect.
